// File: rtl/cache_lookup_ctrl.sv
// Lookup/refill controller for a 2-way, 64-set, 16-byte-line read-only cache.
// Drives cache_mem_wrap and a 4-beat refill bus; flushes all lines after reset.
module cache_lookup_ctrl #(
    parameter int NUM_SETS   = 64,
    parameter int TAG_WIDTH  = 22,
    parameter int LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_i,
    input  logic [31:0]                addr_i,
    output logic                       gnt_o,
    output logic                       rvalid_o,
    output logic [31:0]                rdata_o,
    input  logic                       flush_i,
    output logic                       busy_o,
    output logic [5:0]                 mem_set_o,
    output logic                       mem_way_o,
    output logic                       mem_enable_o,
    output logic                       mem_we_o,
    output logic                       mem_val_we_o,
    output logic                       mem_valid_wr_o,
    output logic [TAG_WIDTH-1:0]       mem_tag_wr_o,
    output logic [LINE_WORDS*32-1:0]   mem_line_wr_o,
    output logic [15:0]                mem_be_o,
    input  logic [1:0]                 mem_valid_rd_i,
    input  logic [TAG_WIDTH-1:0]       mem_tag_rd_i,
    input  logic [LINE_WORDS*32-1:0]   mem_line_rd_i,
    output logic                       refill_req_o,
    output logic [31:0]                refill_addr_o,
    input  logic                       refill_gnt_i,
    input  logic                       refill_rvalid_i,
    input  logic [31:0]                refill_rdata_i
);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_TAG0,
        S_TAG1,
        S_REFILL_REQ,
        S_REFILL_DATA,
        S_WRITE
    } state_e;

    state_e                     state_q;
    logic [6:0]                 flush_cnt_q;
    logic [NUM_SETS-1:0]        lru_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic [5:0]                 idx_q;
    logic [1:0]                 word_q;
    logic                       victim_q;
    logic [1:0]                 beat_q;
    logic [LINE_WORDS*32-1:0]   line_q;
    logic                       rvalid_q;
    logic [31:0]                rdata_q;
    logic                       flush_pend_q;

    logic        idle;
    logic        hit0;
    logic        hit1;
    logic [31:0] hit_word;
    logic [31:0] fill_word;
    logic        unused_addr;

    assign unused_addr = ^addr_i[1:0];

    assign idle      = (state_q == S_IDLE);
    assign gnt_o     = idle && !reset && req_i && !flush_i && !flush_pend_q;
    assign busy_o    = !idle;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign mem_be_o  = 16'hFFFF;

    assign hit0      = mem_valid_rd_i[0] && (mem_tag_rd_i == tag_q);
    assign hit1      = mem_valid_rd_i[1] && (mem_tag_rd_i == tag_q);
    assign hit_word  = mem_line_rd_i[{word_q, 5'b0} +: 32];
    assign fill_word = line_q[{word_q, 5'b0} +: 32];

    assign refill_req_o  = (state_q == S_REFILL_REQ) && !reset;
    assign refill_addr_o = {tag_q, idx_q, 4'b0000};

    // Memory strobes are combinational so a read issued in one state is
    // answered by the memory in the very next state.
    always_comb begin
        mem_enable_o   = 1'b0;
        mem_we_o       = 1'b0;
        mem_val_we_o   = 1'b0;
        mem_valid_wr_o = 1'b0;
        mem_set_o      = idx_q;
        mem_way_o      = 1'b0;
        mem_tag_wr_o   = tag_q;
        mem_line_wr_o  = line_q;
        if (!reset) begin
            unique case (state_q)
                S_FLUSH: begin
                    mem_enable_o = 1'b1;
                    mem_val_we_o = 1'b1;
                    mem_set_o    = flush_cnt_q[6:1];
                    mem_way_o    = flush_cnt_q[0];
                end
                S_IDLE: begin
                    if (gnt_o) begin
                        mem_enable_o = 1'b1;
                        mem_set_o    = addr_i[9:4];
                    end
                end
                S_TAG0: begin
                    if (!hit0 && mem_valid_rd_i[1]) begin
                        mem_enable_o = 1'b1;
                        mem_way_o    = 1'b1;
                    end
                end
                S_WRITE: begin
                    mem_enable_o   = 1'b1;
                    mem_we_o       = 1'b1;
                    mem_val_we_o   = 1'b1;
                    mem_valid_wr_o = 1'b1;
                    mem_way_o      = victim_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FLUSH;
            flush_cnt_q  <= 7'd0;
            lru_q        <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'd0;
            flush_pend_q <= 1'b0;
            beat_q       <= 2'd0;
        end else begin
            rvalid_q <= 1'b0;
            if (flush_i && !idle) begin
                flush_pend_q <= 1'b1;
            end
            unique case (state_q)
                S_FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + 7'd1;
                    if (flush_cnt_q == 7'd127) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (flush_pend_q || flush_i) begin
                        flush_pend_q <= 1'b0;
                        flush_cnt_q  <= 7'd0;
                        state_q      <= S_FLUSH;
                    end else if (req_i) begin
                        tag_q   <= addr_i[31:10];
                        idx_q   <= addr_i[9:4];
                        word_q  <= addr_i[3:2];
                        state_q <= S_TAG0;
                    end
                end
                S_TAG0: begin
                    // Prefer an empty way; otherwise evict the LRU way.
                    if (!mem_valid_rd_i[0]) begin
                        victim_q <= 1'b0;
                    end else if (!mem_valid_rd_i[1]) begin
                        victim_q <= 1'b1;
                    end else begin
                        victim_q <= lru_q[idx_q];
                    end
                    if (hit0) begin
                        rvalid_q      <= 1'b1;
                        rdata_q       <= hit_word;
                        lru_q[idx_q]  <= 1'b1;
                        state_q       <= S_IDLE;
                    end else if (mem_valid_rd_i[1]) begin
                        state_q <= S_TAG1;
                    end else begin
                        state_q <= S_REFILL_REQ;
                    end
                end
                S_TAG1: begin
                    if (hit1) begin
                        rvalid_q      <= 1'b1;
                        rdata_q       <= hit_word;
                        lru_q[idx_q]  <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        state_q <= S_REFILL_REQ;
                    end
                end
                S_REFILL_REQ: begin
                    if (refill_gnt_i) begin
                        beat_q  <= 2'd0;
                        state_q <= S_REFILL_DATA;
                    end
                end
                S_REFILL_DATA: begin
                    if (refill_rvalid_i) begin
                        line_q[{beat_q, 5'b0} +: 32] <= refill_rdata_i;
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    rvalid_q     <= 1'b1;
                    rdata_q      <= fill_word;
                    lru_q[idx_q] <= ~victim_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_FLUSH;
            endcase
        end
    end

endmodule
